// File: rtl/mem_wb_if.sv
// MEM->WB beat interface: valid/ready handshake plus write-back payload.
//   valid      : beat present (master -> slave)
//   ready      : slave can take the beat (slave -> master)
//   wb_en      : register-file write enable
//   mem_read   : load; WB selects mem_data instead of alu_result
//   alu_result : ALU result / address
//   mem_data   : data memory read data
//   dest       : destination register index
interface mem_wb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEST_W = 4
);
  logic              valid;
  logic              ready;
  logic              wb_en;
  logic              mem_read;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DEST_W-1:0] dest;

  modport master (
    output valid, wb_en, mem_read, alu_result, mem_data, dest,
    input  ready
  );

  modport slave (
    input  valid, wb_en, mem_read, alu_result, mem_data, dest,
    output ready
  );
endinterface

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB elastic pipeline register with a 2-entry skid buffer.
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous reset, active-low
//   flush_i     : synchronous discard of all held beats
//   in_if       : slave side, beats from MEM (in_if.ready = stage can accept)
//   out_if      : master side, beats to WB (wb_en/mem_read gated by valid)
//   occupancy_o : beats held (0, 1 or 2)
// in_ready depends only on the state register, never on out_if.ready.
module mem_wb_elastic_reg #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEST_W         = 4,
  parameter int unsigned ZERO_ON_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  mem_wb_if.slave          in_if,
  mem_wb_if.master         out_if,
  output logic [1:0]       occupancy_o
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_read;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem_data;
    logic [DEST_W-1:0] dest;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_beat;
  logic     in_ready;
  logic     out_valid;
  logic     accept;
  logic     drain;

  assign in_beat = '{wb_en:    in_if.wb_en,
                     mem_read: in_if.mem_read,
                     alu:      in_if.alu_result,
                     mem_data: in_if.mem_data,
                     dest:     in_if.dest};

  // Handshake decode straight from the state register (gated while in reset).
  assign in_ready  = (state_q != TWO) & reset;
  assign out_valid = (state_q != EMPTY) & reset;
  assign accept    = in_if.valid & in_ready;
  assign drain     = out_valid & out_if.ready;

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state and entry steering.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Main keeps its data so a non-zeroing bubble still shows the last beat.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode: controls always gated by valid, payload optionally zeroed.
  logic payload_en;
  assign payload_en = reset & (out_valid | (ZERO_ON_BUBBLE == 0));

  assign in_if.ready        = in_ready;
  assign out_if.valid       = out_valid;
  assign out_if.wb_en       = main_q.wb_en & out_valid;
  assign out_if.mem_read    = main_q.mem_read & out_valid;
  assign out_if.alu_result  = payload_en ? main_q.alu      : '0;
  assign out_if.mem_data    = payload_en ? main_q.mem_data : '0;
  assign out_if.dest        = payload_en ? main_q.dest     : '0;
  assign occupancy_o        = reset ? state_q : 2'd0;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed bench for mem_wb_elastic_reg: a zeroing instance (dut) and a
// payload-holding instance (dut_h) see identical stimulus.
module tb_mem_wb_elastic_reg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [1:0] occ, occ_h;
  int total = 0;
  int bad   = 0;

  mem_wb_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) in_a ();
  mem_wb_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) out_a ();
  mem_wb_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) in_b ();
  mem_wb_if #(.DATA_W(DATA_W), .DEST_W(DEST_W)) out_b ();

  assign in_b.valid      = in_a.valid;
  assign in_b.wb_en      = in_a.wb_en;
  assign in_b.mem_read   = in_a.mem_read;
  assign in_b.alu_result = in_a.alu_result;
  assign in_b.mem_data   = in_a.mem_data;
  assign in_b.dest       = in_a.dest;
  assign out_b.ready     = out_a.ready;

  always #5 clk = ~clk;

  mem_wb_elastic_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .ZERO_ON_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_if(in_a), .out_if(out_a), .occupancy_o(occ));

  mem_wb_elastic_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .ZERO_ON_BUBBLE(0)) dut_h (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_if(in_b), .out_if(out_b), .occupancy_o(occ_h));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wb, input logic mr,
                       input logic [31:0] alu, input logic [31:0] md,
                       input logic [3:0] dst);
    in_a.valid      = v;
    in_a.wb_en      = wb;
    in_a.mem_read   = mr;
    in_a.alu_result = alu;
    in_a.mem_data   = md;
    in_a.dest       = dst;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_a.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 4'd9);
    step(); step();
    total++; if (in_a.ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_a.ready); end
    total++; if (out_a.valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_a.valid); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occ); end
    total++; if (out_a.wb_en !== 1'b0 || out_a.alu_result !== 32'h0) begin
      bad++; $display("FAIL rst_payload got wb=%b alu=%h exp 0/0", out_a.wb_en, out_a.alu_result); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    reset = 1'b1;
    #1;
    total++; if (in_a.ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_a.ready); end
  endtask

  task automatic test_stream();
    logic [31:0] alus [3];
    alus[0] = 32'h10; alus[1] = 32'h20; alus[2] = 32'h30;
    out_a.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, alus[i], 32'h0, 4'(i + 1));
      step();
      total++; if (out_a.valid !== 1'b1 || out_a.alu_result !== alus[i] || out_a.dest !== 4'(i + 1)) begin
        bad++; $display("FAIL stream_%0d got v=%b alu=%h dst=%0d exp v=1 alu=%h dst=%0d",
                        i, out_a.valid, out_a.alu_result, out_a.dest, alus[i], i + 1); end
      total++; if (occ !== 2'd1) begin bad++; $display("FAIL stream_occ_%0d got=%0d exp=1", i, occ); end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    step();
    total++; if (out_a.valid !== 1'b0 || out_a.alu_result !== 32'h0) begin
      bad++; $display("FAIL stream_empty got v=%b alu=%h exp v=0 alu=0", out_a.valid, out_a.alu_result); end
  endtask

  task automatic test_backpressure();
    out_a.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1); step();
    total++; if (occ !== 2'd1 || out_a.alu_result !== 32'hA) begin
      bad++; $display("FAIL bp_one got occ=%0d alu=%h exp 1/a", occ, out_a.alu_result); end
    drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2); step();
    total++; if (occ !== 2'd2 || in_a.ready !== 1'b0 || out_a.alu_result !== 32'hA) begin
      bad++; $display("FAIL bp_two got occ=%0d rdy=%b alu=%h exp 2/0/a", occ, in_a.ready, out_a.alu_result); end
    drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd3); step();
    total++; if (occ !== 2'd2 || out_a.alu_result !== 32'hA || out_a.dest !== 4'd1) begin
      bad++; $display("FAIL bp_hold got occ=%0d alu=%h dst=%0d exp 2/a/1", occ, out_a.alu_result, out_a.dest); end
    out_a.ready = 1'b1;
    #1;
    total++; if (in_a.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_indep got=%b exp=0", in_a.ready); end
    step();
    total++; if (occ !== 2'd1 || out_a.alu_result !== 32'hB) begin
      bad++; $display("FAIL bp_drain_b got occ=%0d alu=%h exp 1/b", occ, out_a.alu_result); end
    step();
    total++; if (occ !== 2'd1 || out_a.alu_result !== 32'hC) begin
      bad++; $display("FAIL bp_drain_c got occ=%0d alu=%h exp 1/c", occ, out_a.alu_result); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0); step();
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL bp_empty got=%0d exp=0", occ); end
  endtask

  task automatic test_accept_drain();
    out_a.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 4'd5); step();
    out_a.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h6, 32'h0, 4'd6); step();
    total++; if (occ !== 2'd1 || out_a.alu_result !== 32'h6 || out_a.dest !== 4'd6) begin
      bad++; $display("FAIL ad_swap got occ=%0d alu=%h dst=%0d exp 1/6/6", occ, out_a.alu_result, out_a.dest); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0); step();
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL ad_empty got=%0d exp=0", occ); end
  endtask

  task automatic test_flush();
    out_a.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1); step();
    drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2); step();
    out_a.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'd3);
    flush = 1'b1; step();
    flush = 1'b0;
    total++; if (out_a.valid !== 1'b0 || out_a.wb_en !== 1'b0 || occ !== 2'd0 ||
                 out_a.alu_result !== 32'h0 || out_a.dest !== 4'd0) begin
      bad++; $display("FAIL flush_state got v=%b wb=%b occ=%0d alu=%h dst=%0d exp 0/0/0/0/0",
                      out_a.valid, out_a.wb_en, occ, out_a.alu_result, out_a.dest); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0); step();
    total++; if (out_a.valid !== 1'b0 || occ !== 2'd0) begin
      bad++; $display("FAIL flush_no_c got v=%b occ=%0d exp 0/0", out_a.valid, occ); end
  endtask

  task automatic test_bubble();
    out_a.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h77, 32'h99, 4'd7); step();
    total++; if (out_a.wb_en !== 1'b1 || out_a.mem_read !== 1'b1 || out_a.mem_data !== 32'h99) begin
      bad++; $display("FAIL bub_live got wb=%b mr=%b md=%h exp 1/1/99", out_a.wb_en, out_a.mem_read, out_a.mem_data); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0); step();
    total++; if (out_a.wb_en !== 1'b0 || out_a.mem_read !== 1'b0 || out_a.mem_data !== 32'h0) begin
      bad++; $display("FAIL bub_gate got wb=%b mr=%b md=%h exp 0/0/0", out_a.wb_en, out_a.mem_read, out_a.mem_data); end
    total++; if (out_b.valid !== 1'b0 || out_b.wb_en !== 1'b0 || out_b.mem_read !== 1'b0 ||
                 out_b.alu_result !== 32'h77 || out_b.mem_data !== 32'h99 || out_b.dest !== 4'd7) begin
      bad++; $display("FAIL bub_hold got v=%b wb=%b mr=%b alu=%h md=%h dst=%0d exp 0/0/0/77/99/7",
                      out_b.valid, out_b.wb_en, out_b.mem_read, out_b.alu_result, out_b.mem_data, out_b.dest); end
  endtask

  task automatic test_reset_mid();
    out_a.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 4'd1); step();
    drive(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 4'd2); step();
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL rm_fill got=%0d exp=2", occ); end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    reset = 1'b0;
    #1;
    total++; if (in_a.ready !== 1'b0) begin bad++; $display("FAIL rm_ready_in_reset got=%b exp=0", in_a.ready); end
    step();
    reset = 1'b1;
    #1;
    total++; if (occ !== 2'd0 || out_a.wb_en !== 1'b0 || in_a.ready !== 1'b1 || occ_h !== 2'd0) begin
      bad++; $display("FAIL rm_after got occ=%0d wb=%b rdy=%b occ_h=%0d exp 0/0/1/0", occ, out_a.wb_en, in_a.ready, occ_h); end
    out_a.ready = 1'b1;
    step();
    total++; if (out_a.valid !== 1'b0) begin bad++; $display("FAIL rm_no_replay got=%b exp=0", out_a.valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_accept_drain();
    test_flush();
    test_bubble();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_elastic_reg.md
Name: mem_wb_elastic_reg

Overview:
- Parametrised MEM→WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Carries wb_en, mem_read, ALU result, memory data and destination register.
- Lets WB stall MEM without a combinational ready path.
- Adds synchronous flush and bubble-gating of write-back controls, so a stalled or flushed slot never writes the register file.

Parameters:
- DATA_W, 32, width of ALU result and memory read data.
- DEST_W, 4, width of destination register index.
- ZERO_ON_BUBBLE, 1, 1: output payload forced to 0 when out_valid=0; 0: payload holds last value.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low
- flush  input  1  synchronous discard of all held beats
- in_valid  input  1  MEM beat present
- in_ready  output  1  stage can accept a beat this cycle
- in_wb_en  input  1  write-back enable
- in_mem_read  input  1  load instruction (selects mem data in WB)
- in_alu_result  input  DATA_W  ALU result / address
- in_mem_data  input  DATA_W  data memory read data
- in_dest  input  DEST_W  destination register
- out_valid  output  1  WB beat present
- out_ready  input  1  WB consumes beat
- out_wb_en  output  1  main.wb_en & out_valid
- out_mem_read  output  1  main.mem_read & out_valid
- out_alu_result  output  DATA_W  held ALU result
- out_mem_data  output  DATA_W  held memory data
- out_dest  output  DEST_W  held destination
- occupancy  output  2  beats held (0, 1 or 2)

Behaviour:
- Clock and reset: one clock; all state updates on the rising edge of clk. Reset is synchronous, active-low: reset=0 sampled at the edge → state EMPTY, both entries cleared to 0.
- Outputs during reset: while reset=0, in_ready=0 and all outputs are 0.
- Storage: two entries, main (drives outputs) and skid. Each entry holds {wb_en, mem_read, alu, mem_data, dest}.
- Handshake definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Combinational outputs from the state register: in_ready = (state != TWO) & reset; out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/ONE/TWO. in_ready has no combinational dependence on out_ready.
- States and transitions (evaluated when reset=1 and flush=0):
  - EMPTY:
    - accept → main ← input; go to ONE.
    - otherwise stay EMPTY.
  - ONE:
    - accept & drain → main ← input; stay ONE.
    - accept & !drain → skid ← input; go to TWO.
    - !accept & drain → go to EMPTY.
    - neither → hold.
  - TWO (in_ready=0):
    - drain → main ← skid; go to ONE.
    - otherwise hold.
- Ordering: beats leave strictly in acceptance order; none are dropped or duplicated except on flush.
- Latency and throughput:
  - 1 cycle from accept to out_valid when EMPTY.
  - Sustained 1 beat/cycle when out_ready is held at 1.
- Flush: flush=1 at an edge (reset=1) → state EMPTY, both entries invalidated.
  - Any beat accepted in the same cycle is discarded.
  - A drain in the same cycle still counts as consumed by WB.
  - Flush outranks every transition; reset outranks flush.
- Write-back gating: out_wb_en and out_mem_read are never 1 while out_valid=0.
- Bubble payload:
  - ZERO_ON_BUBBLE=1 → out_alu_result, out_mem_data and out_dest are 0 when EMPTY.
  - ZERO_ON_BUBBLE=0 → those outputs hold the last main contents.
- Stalled payload: while out_valid=1 & out_ready=0, all out_* stay stable.
- Input stability: in_* are sampled only on accept; they may change freely when in_valid=0.
- Reset mid-operation: reset asserted in state TWO → next cycle EMPTY, occupancy=0, out_wb_en=0. Held beats are not replayed.
- Widths: no arithmetic; fields pass through bit-exact at DATA_W/DEST_W.

Test Plan:
- Reset then streaming: reset=0 for 2 cycles, then three beats (alu=0x10/0x20/0x30, dest=1/2/3, wb_en=1) with out_ready=1 → out_valid rises 1 cycle after first accept; outputs show 0x10, 0x20, 0x30 on consecutive cycles; occupancy stays 1.
- Backpressure fill: out_ready=0, send alu=0xA, then 0xB → occupancy 1 then 2, in_ready=0. Beat 0xC held off until out_ready=1. Outputs then 0xA, 0xB, 0xC in order.
- Simultaneous accept/drain in ONE: main=0x5, in=0x6, out_ready=1 → next cycle out_alu_result=0x6, occupancy=1, skid unused.
- Flush: state TWO (0xA, 0xB), flush=1 with in_valid=1 (0xC) → next cycle out_valid=0, out_wb_en=0, occupancy=0, outputs 0 (ZERO_ON_BUBBLE=1). 0xC never appears.
- Bubble gating: beat with wb_en=1, mem_read=1 drained, no new input → out_wb_en=0 and out_mem_read=0 the following cycle. With ZERO_ON_BUBBLE=0, out_alu_result retains its value.
- Reset mid-stall: state TWO, out_ready=0, reset=0 for one edge → occupancy=0, in_ready=0 during reset, then in_ready=1 after release.
